// File: rtl/axi4_lite_manager_pkg.sv
// Shared types and constants for the AXI4-Lite manager bridge: word format,
// default timeout, FSM encoding and AXI response codes.
package axi4_lite_manager_pkg;

  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  localparam int DEFAULT_AXI_TIMEOUT = 256;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_ADDR  = 3'd1,
    ST_READ_DATA  = 3'd2,
    ST_WRITE      = 3'd3,
    ST_WRITE_RESP = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // Anything other than a plain OKAY is reported to the requester as a fault.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_manager_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R) with manager and subordinate views.
interface axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 32
);
  import axi4_lite_manager_pkg::*;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;

  modport manager (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport subordinate (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_manager_timeout_counter.sv
// Counts busy cycles of one transaction and flags when the limit is reached.
module axi4_lite_timeout_counter
  import axi4_lite_manager_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_AXI_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_r;

  // Saturates at the limit so a stale count never wraps back into range.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == CW'(TIMEOUT));

endmodule

// File: rtl/axi4_lite_manager.sv
// Bridges a held-enable load/store request port onto a single-outstanding
// AXI4-Lite manager port, with error/timeout reporting.
module axi4_lite_manager
  import axi4_lite_manager_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_AXI_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  word_t                 wr_data,
  input  logic [XLEN/8-1:0]     wr_strobe,
  output word_t                 rd_data,
  output logic                  access_fault,
  output logic                  busy,
  axi4_lite.manager             axi_m
);

  state_e                state_r;
  state_e                state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  word_t                 wdata_r;
  logic [XLEN/8-1:0]     wstrb_r;
  word_t                 rd_data_r;
  logic                  aw_done_r;
  logic                  w_done_r;

  logic                  in_flight_s;
  logic                  live_s;
  logic                  expired_s;
  logic                  start_s;
  logic                  ar_hs_s;
  logic                  r_hs_s;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  b_hs_s;

  axi4_lite_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_s),
    .enable  (in_flight_s),
    .expired (expired_s)
  );

  // Channel drives and requester status; an expired transaction drops every valid/ready at once.
  always_comb begin
    in_flight_s   = !rst && (state_r != ST_IDLE);
    live_s        = in_flight_s && !expired_s;

    axi_m.arvalid = live_s && (state_r == ST_READ_ADDR);
    axi_m.araddr  = addr_r;
    axi_m.arprot  = 3'b000;
    axi_m.rready  = live_s && (state_r == ST_READ_DATA);
    axi_m.awvalid = live_s && (state_r == ST_WRITE) && !aw_done_r;
    axi_m.awaddr  = addr_r;
    axi_m.awprot  = 3'b000;
    axi_m.wvalid  = live_s && (state_r == ST_WRITE) && !w_done_r;
    axi_m.wdata   = wdata_r;
    axi_m.wstrb   = wstrb_r;
    axi_m.bready  = live_s && (state_r == ST_WRITE_RESP);

    ar_hs_s       = axi_m.arvalid && axi_m.arready;
    r_hs_s        = axi_m.rvalid  && axi_m.rready;
    aw_hs_s       = axi_m.awvalid && axi_m.awready;
    w_hs_s        = axi_m.wvalid  && axi_m.wready;
    b_hs_s        = axi_m.bvalid  && axi_m.bready;

    start_s       = !rst && (state_r == ST_IDLE) && (rd_en || wr_en);
    busy          = live_s && !r_hs_s && !b_hs_s;
    access_fault  = (in_flight_s && expired_s)
                  || (r_hs_s && resp_is_error(axi_m.rresp))
                  || (b_hs_s && resp_is_error(axi_m.bresp));

    if (r_hs_s) begin
      rd_data = axi_m.rdata;
    end else if (rst) begin
      rd_data = '0;
    end else begin
      rd_data = rd_data_r;
    end
  end

  // Next-state selection; reads win over writes when both enables are up.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_en) begin
          state_next_s = ST_READ_ADDR;
        end else if (wr_en) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ_ADDR: begin
        if (expired_s) begin
          state_next_s = ST_IDLE;
        end else if (ar_hs_s) begin
          state_next_s = ST_READ_DATA;
        end else begin
          state_next_s = ST_READ_ADDR;
        end
      end
      ST_READ_DATA: begin
        if (expired_s || r_hs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_READ_DATA;
        end
      end
      ST_WRITE: begin
        if (expired_s) begin
          state_next_s = ST_IDLE;
        end else if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_next_s = ST_WRITE_RESP;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_WRITE_RESP: begin
        if (expired_s || b_hs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request capture: the bus is driven from these copies, not the live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
    end else if (start_s) begin
      addr_r  <= addr;
      wdata_r <= wr_data;
      wstrb_r <= wr_strobe;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  // AW and W complete independently; each flag retires its own valid.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      aw_done_r <= aw_done_r || aw_hs_s;
      w_done_r  <= w_done_r  || w_hs_s;
    end
  end

  // Last read data, held until the next read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (r_hs_s) begin
      rd_data_r <= axi_m.rdata;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

endmodule

// File: tb/tb_axi4_lite_manager.sv
// Directed bench for axi4_lite_manager: scripted AXI subordinate, transaction-level
// reference model checked every cycle, plus hand-computed per-scenario expectations.
module tb_axi4_lite_manager;
  import axi4_lite_manager_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic [31:0] rd_data;
  logic        access_fault;
  logic        busy;

  axi4_lite #(.ADDR_WIDTH(32), .WIDTH(32)) bus ();

  axi4_lite_manager #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .wr_strobe    (wr_strobe),
    .rd_data      (rd_data),
    .access_fault (access_fault),
    .busy         (busy),
    .axi_m        (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // Subordinate knobs
  bit          fast, ar_never, aw_never, w_never, sub_clear;
  int          ar_lat, aw_lat, w_lat, r_lat, b_lat;
  logic [31:0] r_data_k;
  logic [1:0]  r_resp_k, b_resp_k;

  // Scripted subordinate: decides at negedge, drives just after posedge.
  initial begin : responder
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit r_act, b_act, aw_ok, w_ok;
    logic n_arready, n_rvalid, n_awready, n_wready, n_bvalid;
    logic [31:0] n_rdata;
    logic [1:0]  n_rresp, n_bresp;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    r_act = 0; b_act = 0; aw_ok = 0; w_ok = 0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    forever begin
      @(negedge clk);
      n_arready = bus.arready; n_rvalid = bus.rvalid; n_rdata = bus.rdata; n_rresp = bus.rresp;
      n_awready = bus.awready; n_wready = bus.wready; n_bvalid = bus.bvalid; n_bresp = bus.bresp;
      if (rst || sub_clear) begin
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_act = 0; b_act = 0; aw_ok = 0; w_ok = 0;
        n_arready = fast; n_awready = fast; n_wready = fast;
        n_rvalid = 1'b0; n_bvalid = 1'b0; n_rdata = 32'h0; n_rresp = 2'b00; n_bresp = 2'b00;
      end else begin
        if (bus.arvalid && bus.arready) begin
          ar_cnt = 0; r_act = 1; r_cnt = r_lat; n_arready = fast;
        end else if (bus.arvalid && !ar_never) begin
          ar_cnt++;
          if (ar_cnt >= ar_lat) n_arready = 1'b1;
        end
        if (bus.rvalid && bus.rready) begin
          n_rvalid = 1'b0; r_act = 0; n_rdata = 32'h0; n_rresp = 2'b00;
        end else if (r_act && !bus.rvalid) begin
          r_cnt--;
          if (r_cnt <= 0) begin
            n_rvalid = 1'b1; n_rdata = r_data_k; n_rresp = r_resp_k;
          end
        end
        if (bus.awvalid && bus.awready) begin
          aw_ok = 1; aw_cnt = 0; n_awready = fast;
        end else if (bus.awvalid && !aw_never) begin
          aw_cnt++;
          if (aw_cnt >= aw_lat) n_awready = 1'b1;
        end
        if (bus.wvalid && bus.wready) begin
          w_ok = 1; w_cnt = 0; n_wready = fast;
        end else if (bus.wvalid && !w_never) begin
          w_cnt++;
          if (w_cnt >= w_lat) n_wready = 1'b1;
        end
        if (bus.bvalid && bus.bready) begin
          n_bvalid = 1'b0; b_act = 0; n_bresp = 2'b00;
        end else if (aw_ok && w_ok && !b_act) begin
          b_act = 1; b_cnt = b_lat; aw_ok = 0; w_ok = 0;
        end
        if (b_act && !bus.bvalid) begin
          b_cnt--;
          if (b_cnt <= 0) begin
            n_bvalid = 1'b1; n_bresp = b_resp_k;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.arready = n_arready; bus.rvalid = n_rvalid; bus.rdata = n_rdata; bus.rresp = n_rresp;
      bus.awready = n_awready; bus.wready = n_wready; bus.bvalid = n_bvalid; bus.bresp = n_bresp;
    end
  end

  // Transaction-level reference: what is outstanding, how old it is, which beats remain.
  int          m_kind = 0;   // 0 none, 1 read, 2 write
  int          m_age  = 0;
  bit          m_ar = 0, m_aw = 0, m_w = 0;
  logic [31:0] m_addr = 32'h0, m_wd = 32'h0, m_rd = 32'h0;
  logic [3:0]  m_st = 4'h0;

  always @(negedge clk) begin : compare
    bit ab, earv, err, eawv, ewv, ebr, rdn, bdn, ef, eb;
    logic [31:0] erd;
    if (rst) begin
      chk("rst_arvalid", {31'b0, bus.arvalid}, 32'd0);
      chk("rst_rready",  {31'b0, bus.rready},  32'd0);
      chk("rst_awvalid", {31'b0, bus.awvalid}, 32'd0);
      chk("rst_wvalid",  {31'b0, bus.wvalid},  32'd0);
      chk("rst_bready",  {31'b0, bus.bready},  32'd0);
      chk("rst_busy",    {31'b0, busy},        32'd0);
      chk("rst_fault",   {31'b0, access_fault}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
    end else begin
      ab   = (m_kind != 0) && (m_age == TO);
      earv = (m_kind == 1) && m_ar && !ab;
      err  = (m_kind == 1) && !m_ar && !ab;
      eawv = (m_kind == 2) && m_aw && !ab;
      ewv  = (m_kind == 2) && m_w && !ab;
      ebr  = (m_kind == 2) && !m_aw && !m_w && !ab;
      rdn  = err && bus.rvalid;
      bdn  = ebr && bus.bvalid;
      erd  = rdn ? bus.rdata : m_rd;
      ef   = ab || (rdn && bus.rresp != 2'b00) || (bdn && bus.bresp != 2'b00);
      eb   = (m_kind != 0) && !ab && !rdn && !bdn;
      chk("arvalid", {31'b0, bus.arvalid}, {31'b0, earv});
      chk("rready",  {31'b0, bus.rready},  {31'b0, err});
      chk("awvalid", {31'b0, bus.awvalid}, {31'b0, eawv});
      chk("wvalid",  {31'b0, bus.wvalid},  {31'b0, ewv});
      chk("bready",  {31'b0, bus.bready},  {31'b0, ebr});
      chk("busy",    {31'b0, busy},        {31'b0, eb});
      chk("fault",   {31'b0, access_fault}, {31'b0, ef});
      chk("rd_data", rd_data, erd);
      if (earv) begin
        chk("araddr", bus.araddr, m_addr);
        chk("arprot", {29'b0, bus.arprot}, 32'd0);
      end
      if (eawv) begin
        chk("awaddr", bus.awaddr, m_addr);
        chk("awprot", {29'b0, bus.awprot}, 32'd0);
      end
      if (ewv) begin
        chk("wdata", bus.wdata, m_wd);
        chk("wstrb", {28'b0, bus.wstrb}, {28'b0, m_st});
      end
      // advance to the state seen after the coming edge
      if (m_kind == 0) begin
        if (rd_en) begin
          m_kind = 1; m_ar = 1; m_age = 0; m_addr = addr;
        end else if (wr_en) begin
          m_kind = 2; m_aw = 1; m_w = 1; m_age = 0;
          m_addr = addr; m_wd = wr_data; m_st = wr_strobe;
        end
      end else if (ab) begin
        m_kind = 0;
      end else begin
        m_age++;
        if (m_kind == 1) begin
          if (earv && bus.arready) m_ar = 0;
          if (rdn) begin m_rd = bus.rdata; m_kind = 0; end
        end else begin
          if (eawv && bus.awready) m_aw = 0;
          if (ewv && bus.wready) m_w = 0;
          if (bdn) m_kind = 0;
        end
      end
    end
    if (rst) begin
      m_kind = 0; m_rd = 32'h0; m_age = 0;
    end
  end

  // Snapshots from the requester side
  int          n_cyc;
  logic        s_arvalid, s_awvalid, s_wvalid, s_busy3, s_f, s_arv_end;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rd;
  logic [3:0]  s_wstrb;

  task automatic sub_setup(input bit f, input int al, input int rl, input int awl,
                           input int wl, input int bl, input logic [31:0] rd_v,
                           input logic [1:0] rr, input logic [1:0] br);
    fast = f; ar_lat = al; r_lat = rl; aw_lat = awl; w_lat = wl; b_lat = bl;
    r_data_k = rd_v; r_resp_k = rr; b_resp_k = br;
    ar_never = 0; aw_never = 0; w_never = 0;
    sub_clear = 1;
    @(posedge clk); #1;
    sub_clear = 0;
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bit done;
    rd_en = rd; wr_en = wr; addr = a; wr_data = d; wr_strobe = s;
    @(posedge clk); #1;
    n_cyc = 0; done = 0;
    while (!done && n_cyc < 100) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 1) begin
        s_arvalid = bus.arvalid; s_awvalid = bus.awvalid; s_wvalid = bus.wvalid;
        s_araddr = bus.araddr; s_awaddr = bus.awaddr; s_wdata = bus.wdata; s_wstrb = bus.wstrb;
      end
      if (n_cyc == 3) s_busy3 = busy;
      if (!busy) begin
        done = 1; s_rd = rd_data; s_f = access_fault; s_arv_end = bus.arvalid;
      end
    end
    if (!done) chk("txn_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; wr_data = 32'h0; wr_strobe = 4'h0;
    fast = 0; ar_never = 0; aw_never = 0; w_never = 0; sub_clear = 0;
    ar_lat = 1; r_lat = 1; aw_lat = 1; w_lat = 1; b_lat = 1;
    r_data_k = 32'h0; r_resp_k = 2'b00; b_resp_k = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_fault", {31'b0, access_fault}, 32'd0);
    chk("post_rst_rd_data", rd_data, 32'd0);
    chk("post_rst_arvalid", {31'b0, bus.arvalid}, 32'd0);

    // Slow read: arready 1 cycle after arvalid, rvalid 2 cycles after that
    sub_setup(1'b0, 1, 2, 1, 1, 1, 32'hDEADBEEF, 2'b00, 2'b00);
    run_txn(1'b1, 1'b0, 32'h12345678, 32'h0, 4'h0);
    chk("sr_araddr", s_araddr, 32'h12345678);
    chk("sr_cycles", n_cyc, 32'd4);
    chk("sr_busy_after_ar", {31'b0, s_busy3}, 32'd1);
    chk("sr_rd_data", s_rd, 32'hDEADBEEF);
    chk("sr_fault", {31'b0, s_f}, 32'd0);
    @(negedge clk);
    chk("sr_idle_busy", {31'b0, busy}, 32'd0);
    chk("sr_rd_hold", rd_data, 32'hDEADBEEF);

    // Slow write: AW accepted first, W later, then OKAY
    sub_setup(1'b0, 1, 1, 1, 3, 2, 32'h0, 2'b00, 2'b00);
    run_txn(1'b0, 1'b1, 32'h00001000, 32'hCAFEF00D, 4'hF);
    chk("sw_awaddr", s_awaddr, 32'h00001000);
    chk("sw_wdata", s_wdata, 32'hCAFEF00D);
    chk("sw_wstrb", {28'b0, s_wstrb}, 32'h0000000F);
    chk("sw_cycles", n_cyc, 32'd6);
    chk("sw_fault", {31'b0, s_f}, 32'd0);

    // Fast read
    sub_setup(1'b1, 0, 1, 0, 0, 1, 32'h0BADF00D, 2'b00, 2'b00);
    run_txn(1'b1, 1'b0, 32'h00000200, 32'h0, 4'h0);
    chk("fr_cycles", n_cyc, 32'd2);
    chk("fr_rd_data", s_rd, 32'h0BADF00D);
    chk("fr_fault", {31'b0, s_f}, 32'd0);

    // Fast write: AW and W in the same cycle
    sub_setup(1'b1, 0, 1, 0, 0, 1, 32'h0, 2'b00, 2'b00);
    run_txn(1'b0, 1'b1, 32'h00000300, 32'h11223344, 4'h5);
    chk("fw_awvalid", {31'b0, s_awvalid}, 32'd1);
    chk("fw_wvalid", {31'b0, s_wvalid}, 32'd1);
    chk("fw_cycles", n_cyc, 32'd2);
    chk("fw_fault", {31'b0, s_f}, 32'd0);

    // Both enables: read wins
    sub_setup(1'b1, 0, 1, 0, 0, 1, 32'h55AA55AA, 2'b00, 2'b00);
    run_txn(1'b1, 1'b1, 32'h00000040, 32'h99999999, 4'hF);
    chk("pri_arvalid", {31'b0, s_arvalid}, 32'd1);
    chk("pri_awvalid", {31'b0, s_awvalid}, 32'd0);
    chk("pri_rd_data", s_rd, 32'h55AA55AA);

    // Read SLVERR
    sub_setup(1'b1, 0, 1, 0, 0, 1, 32'h12121212, 2'b10, 2'b00);
    run_txn(1'b1, 1'b0, 32'h00000400, 32'h0, 4'h0);
    chk("rerr_fault", {31'b0, s_f}, 32'd1);
    chk("rerr_cycles", n_cyc, 32'd2);
    @(negedge clk);
    chk("rerr_fault_gone", {31'b0, access_fault}, 32'd0);

    // Write DECERR
    sub_setup(1'b1, 0, 1, 0, 0, 1, 32'h0, 2'b00, 2'b11);
    run_txn(1'b0, 1'b1, 32'h00000500, 32'hA5A5A5A5, 4'h3);
    chk("werr_fault", {31'b0, s_f}, 32'd1);
    chk("werr_cycles", n_cyc, 32'd2);

    // Timeout: arready never comes
    sub_setup(1'b0, 1, 1, 1, 1, 1, 32'h0, 2'b00, 2'b00);
    ar_never = 1;
    run_txn(1'b1, 1'b0, 32'h00000600, 32'h0, 4'h0);
    chk("to_cycles", n_cyc, 32'd9);
    chk("to_fault", {31'b0, s_f}, 32'd1);
    chk("to_arvalid_dropped", {31'b0, s_arv_end}, 32'd0);
    @(negedge clk);
    chk("to_fault_one_cycle", {31'b0, access_fault}, 32'd0);

    // Reset in the middle of a stalled write
    sub_setup(1'b0, 1, 1, 1, 1, 1, 32'h0, 2'b00, 2'b00);
    aw_never = 1; w_never = 1;
    rd_en = 1'b0; wr_en = 1'b1; addr = 32'h00000700; wr_data = 32'h77777777; wr_strobe = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_awvalid", {31'b0, bus.awvalid}, 32'd1);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_awvalid", {31'b0, bus.awvalid}, 32'd0);
    chk("rw_wvalid", {31'b0, bus.wvalid}, 32'd0);
    chk("rw_busy", {31'b0, busy}, 32'd0);
    chk("rw_fault", {31'b0, access_fault}, 32'd0);
    chk("rw_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_after_awvalid", {31'b0, bus.awvalid}, 32'd0);
    chk("rw_after_busy", {31'b0, busy}, 32'd0);
    chk("rw_after_fault", {31'b0, access_fault}, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
